// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and constants for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE, GRANT)
//   STAT_WIDTH  : width of each per-requester accepted-beat counter
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned STAT_WIDTH = 32;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req   : request vector, one bit per requester
//   last  : index of the most recently granted requester
//   found : at least one request is set
//   idx   : first set request searching upward from last+1, modulo N_REQ
module rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int unsigned IDW = $clog2(N_REQ);

    int unsigned cand;

    // Walk the N_REQ positions after last; the first hit wins.
    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = (32'(last) + k) % N_REQ;
            if (!found && req[IDW'(cand)]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// N_REQ valid/ready producers, granting one producer for up to MAX_BURST beats.
//   CLK, RST             : clock, synchronous active-high reset
//   REQ_VALID/REQ_DATA   : per-requester beat valid and packed data
//   REQ_READY            : per-requester accept (combinational)
//   W_DATA/WEN           : FIFO write data/enable (combinational)
//   FULL                 : FIFO full flag, blocks writes in the same cycle
//   GRANT_ID             : current or last granted requester
//   BUSY                 : high while a grant is active
//   STAT_CLR/STAT_CNT    : accepted-beat counters, only with FIFO_ARB_STATS_EN
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [N_REQ-1:0]              REQ_VALID,
    input  logic [N_REQ*DATA_WIDTH-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]              REQ_READY,
    output logic [DATA_WIDTH-1:0]         W_DATA,
    output logic                          WEN,
    input  logic                          FULL,
    output logic [$clog2(N_REQ)-1:0]      GRANT_ID,
    output logic                          BUSY
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                          STAT_CLR,
    output logic [N_REQ*STAT_WIDTH-1:0]   STAT_CNT
`endif
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned BCW = $clog2(MAX_BURST + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           xfer_c;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (REQ_VALID),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Data mux follows the grant register in every state.
    always_comb begin
        W_DATA = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == IDW'(i)) begin
                W_DATA = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and handshake logic. RST gates ready so no write is
    // issued in the cycle a reset is being taken.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        REQ_READY  = '0;
        xfer_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_idx;
                    last_d     = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                REQ_READY[grant_q] = !FULL && !RST;
                xfer_c             = REQ_VALID[grant_q] && !FULL && !RST;
                if (!REQ_VALID[grant_q]) begin
                    state_d = IDLE;
                end else if (xfer_c) begin
                    beat_cnt_d = beat_cnt_q + BCW'(1);
                    if (beat_cnt_q == BCW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to the top index so requester 0 wins first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            last_q     <= IDW'(N_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign WEN      = xfer_c;
    assign BUSY     = (state_q == GRANT);
    assign GRANT_ID = grant_q;

`ifdef FIFO_ARB_STATS_EN
    logic [STAT_WIDTH-1:0] stat_q [N_REQ];
    logic [STAT_WIDTH-1:0] stat_d [N_REQ];

    // Saturating per-requester beat counters; clear wins over increment.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (STAT_CLR) begin
                stat_d[i] = '0;
            end else if (xfer_c && (grant_q == IDW'(i)) && (stat_q[i] != '1)) begin
                stat_d[i] = stat_q[i] + STAT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (RST) begin
                stat_q[i] <= '0;
            end else begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    always_comb begin
        STAT_CNT = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            STAT_CNT[i*STAT_WIDTH +: STAT_WIDTH] = stat_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed and randomized checks of fifo_wr_arbiter
// against a transaction-level model of producers, the FIFO and the
// round-robin grant rules. Stats checks run when FIFO_ARB_STATS_EN is defined.
module tb_fifo_wr_arbiter;

    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int DEPTH = 16;
    localparam int IDW   = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic              RST;
    logic              FULL;
    logic              WEN;
    logic              BUSY;
    logic [N_REQ-1:0]  valid;
    logic [N_REQ-1:0]  REQ_READY;
    logic [N_REQ*DW-1:0] data_bus;
    logic [DW-1:0]     W_DATA;
    logic [IDW-1:0]    GRANT_ID;
`ifdef FIFO_ARB_STATS_EN
    logic              STAT_CLR;
    logic [N_REQ*32-1:0] STAT_CNT;
    logic [N_REQ*32-1:0] s_stat;
`endif

    fifo_wr_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (valid),
        .REQ_DATA  (data_bus),
        .REQ_READY (REQ_READY),
        .W_DATA    (W_DATA),
        .WEN       (WEN),
        .FULL      (FULL),
        .GRANT_ID  (GRANT_ID),
        .BUSY      (BUSY)
`ifdef FIFO_ARB_STATS_EN
        ,
        .STAT_CLR  (STAT_CLR),
        .STAT_CNT  (STAT_CNT)
`endif
    );

    // Producer beat queues, FIFO contents and logs.
    logic [DW-1:0] pq [N_REQ][$];
    logic [DW-1:0] fq [$];
    logic [DW-1:0] rlog [$];
    int            gq [$];
    int            bq [$];
    int            iq [$];

    logic [N_REQ-1:0] en;
    logic [N_REQ-1:0] acc;
    logic             rd_en;

    // Last sampled DUT outputs.
    logic [N_REQ-1:0] s_ready;
    logic             s_wen;
    logic             s_busy;
    logic [DW-1:0]    s_wdata;
    logic [IDW-1:0]   s_gid;

    // Model state.
    logic             prev_busy;
    logic             prev_rst;
    logic             prev_vg;
    logic [N_REQ-1:0] prev_valid;
    int               last_model;
    int               model_gid;
    int               cur_beats;
    int               idle_run;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Round-robin winner: rotate the request vector so last+1 sits at bit 0.
    function automatic int exp_pick(input logic [N_REQ-1:0] v, input int last);
        logic [2*N_REQ-1:0] dbl;
        dbl = {v, v} >> ((last + 1) % N_REQ);
        for (int j = 0; j < N_REQ; j++) begin
            if (dbl[j]) return (last + 1 + j) % N_REQ;
        end
        return -1;
    endfunction

    // One clock cycle: drive producers, sample and check at negedge,
    // then advance producers and the FIFO model after the edge.
    task automatic cycle();
        logic [N_REQ-1:0] exp_ready;
        int e;
        for (int i = 0; i < N_REQ; i++) begin
            valid[i] = en[i] && (pq[i].size() > 0);
            data_bus[i*DW +: DW] = valid[i] ? pq[i][0] : 8'h00;
        end
        @(negedge CLK);
        s_ready = REQ_READY;
        s_wen   = WEN;
        s_wdata = W_DATA;
        s_busy  = BUSY;
        s_gid   = GRANT_ID;
`ifdef FIFO_ARB_STATS_EN
        s_stat  = STAT_CNT;
`endif
        if (prev_busy && !prev_rst)
            chk("release", 64'(s_busy), 64'(!(!prev_vg || cur_beats == MB)));
        if (!s_busy && prev_busy && !prev_rst)
            bq.push_back(cur_beats);
        if (!prev_busy && !prev_rst && prev_valid != '0)
            chk("arb_latency", 64'(s_busy), 64'd1);
        if (s_busy && !prev_busy) begin
            e = exp_pick(prev_valid, last_model);
            chk("grant_pick", 64'(s_gid), 64'(e));
            last_model = e;
            model_gid  = e;
            gq.push_back(int'(s_gid));
            iq.push_back(idle_run);
            idle_run  = 0;
            cur_beats = 0;
        end
        if (!s_busy) idle_run++;
        if (s_busy && s_wen) cur_beats++;
        chk("grant_id", 64'(s_gid), 64'(model_gid));
        exp_ready = '0;
        if (s_busy && !RST && !FULL) exp_ready[IDW'(model_gid)] = 1'b1;
        chk("ready", 64'(s_ready), 64'(exp_ready));
        chk("wen", 64'(s_wen), 64'(|(valid & s_ready)));
        if (s_wen) chk("wdata", 64'(s_wdata), 64'(data_bus[int'(s_gid)*DW +: DW]));
        chk("burst_max", 64'(cur_beats <= MB), 64'd1);
        prev_busy  = s_busy;
        prev_rst   = RST;
        prev_valid = valid;
        prev_vg    = valid[IDW'(model_gid)];
        @(posedge CLK);
        #1;
        if (RST) begin
            last_model = N_REQ - 1;
            model_gid  = 0;
            prev_busy  = 1'b0;
            cur_beats  = 0;
            idle_run   = 0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            acc[i] = valid[i] && s_ready[i];
            if (acc[i]) void'(pq[i].pop_front());
        end
        if (rd_en && fq.size() > 0) rlog.push_back(fq.pop_front());
        if (s_wen && fq.size() < DEPTH) fq.push_back(s_wdata);
        FULL = (fq.size() >= DEPTH);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        en  = '0;
        for (int i = 0; i < N_REQ; i++) pq[i].delete();
        cycle();
        cycle();
        RST   = 1'b0;
        rd_en = 1'b0;
        fq.delete();
        rlog.delete();
        gq.delete();
        bq.delete();
        iq.delete();
        FULL = 1'b0;
    endtask

    initial begin
        int exp_order [5];
        logic [DW-1:0] exp_rd [3];
        int total;
        exp_order = '{0, 1, 2, 3, 0};
        exp_rd    = '{8'hA1, 8'hA2, 8'hA3};
        RST = 1'b1; FULL = 1'b0; en = '0; acc = '0; rd_en = 1'b0;
        valid = '0; data_bus = '0;
`ifdef FIFO_ARB_STATS_EN
        STAT_CLR = 1'b0;
`endif
        prev_busy = 1'b0; prev_rst = 1'b1; prev_vg = 1'b0; prev_valid = '0;
        last_model = N_REQ - 1; model_gid = 0; cur_beats = 0; idle_run = 0;

        // Reset state
        do_reset();
        cycle();
        chk("rst_busy", 64'(s_busy), 64'd0);
        chk("rst_wen", 64'(s_wen), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_gid", 64'(s_gid), 64'd0);

        // Single requester 2, three beats
        do_reset();
        pq[2].push_back(8'hA1); pq[2].push_back(8'hA2); pq[2].push_back(8'hA3);
        en = '1;
        cycle();
        chk("t2_idle_busy", 64'(s_busy), 64'd0);
        chk("t2_idle_wen", 64'(s_wen), 64'd0);
        for (int b = 0; b < 3; b++) begin
            cycle();
            chk("t2_wen", 64'(s_wen), 64'd1);
            chk("t2_gid", 64'(s_gid), 64'd2);
            chk("t2_wdata", 64'(s_wdata), 64'(exp_rd[b]));
            chk("t2_ready", 64'(s_ready), 64'b0100);
        end
        cycle();
        chk("t2_vlow_wen", 64'(s_wen), 64'd0);
        chk("t2_vlow_busy", 64'(s_busy), 64'd1);
        cycle();
        chk("t2_released", 64'(s_busy), 64'd0);
        chk("t2_gid_hold", 64'(s_gid), 64'd2);
        rd_en = 1'b1;
        for (int b = 0; b < 3; b++) cycle();
        rd_en = 1'b0;
        chk("t2_rd_count", 64'(rlog.size()), 64'd3);
        for (int b = 0; b < 3 && b < rlog.size(); b++)
            chk("t2_rd_data", 64'(rlog[b]), 64'(exp_rd[b]));

        // Contention: all four requesters continuously valid
        do_reset();
        for (int i = 0; i < N_REQ; i++)
            for (int j = 0; j < 24; j++) pq[i].push_back(8'((i << 5) | j));
        en = '1;
        rd_en = 1'b1;
        for (int k = 0; k < 60 && gq.size() < 5; k++) cycle();
        chk("t3_ngrants", 64'(gq.size() >= 5), 64'd1);
        for (int j = 0; j < 5 && j < gq.size(); j++)
            chk("t3_order", 64'(gq[j]), 64'(exp_order[j]));
        for (int j = 0; j < 4 && j < bq.size(); j++)
            chk("t3_beats", 64'(bq[j]), 64'(MB));
        for (int j = 0; j < 5 && j < iq.size(); j++)
            chk("t3_bubble", 64'(iq[j]), 64'd1);

        // Full stall: FIFO pre-filled to DEPTH-1
        do_reset();
        for (int j = 0; j < DEPTH - 1; j++) fq.push_back(8'(j));
        FULL = 1'b0;
        for (int j = 0; j < 4; j++) pq[0].push_back(8'hB0 + 8'(j));
        en = 4'b0001;
        cycle();
        cycle();
        chk("t4_first_wen", 64'(s_wen), 64'd1);
        chk("t4_first_data", 64'(s_wdata), 64'hB0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            chk("t4_stall_wen", 64'(s_wen), 64'd0);
            chk("t4_stall_ready", 64'(s_ready), 64'd0);
            chk("t4_stall_busy", 64'(s_busy), 64'd1);
        end
        rd_en = 1'b1;
        for (int k = 0; k < 20 && (pq[0].size() > 0 || s_busy); k++) cycle();
        chk("t4_drained", 64'(pq[0].size()), 64'd0);
        chk("t4_nbursts", 64'(bq.size()), 64'd1);
        if (bq.size() > 0) chk("t4_beats", 64'(bq[0]), 64'd4);

        // Early release: requester 1 stops after 2 beats, requester 3 waits
        do_reset();
        pq[1].push_back(8'hC0); pq[1].push_back(8'hC1);
        pq[3].push_back(8'hD0); pq[3].push_back(8'hD1); pq[3].push_back(8'hD2);
        en = 4'b1010;
        rd_en = 1'b1;
        cycle();
        cycle();
        chk("t5_gid1", 64'(s_gid), 64'd1);
        cycle();
        cycle();
        chk("t5_vlow_busy", 64'(s_busy), 64'd1);
        chk("t5_vlow_wen", 64'(s_wen), 64'd0);
        cycle();
        chk("t5_bubble", 64'(s_busy), 64'd0);
        cycle();
        chk("t5_gid3", 64'(s_gid), 64'd3);
        chk("t5_wdata", 64'(s_wdata), 64'hD0);
        for (int k = 0; k < 6; k++) cycle();

        // Reset mid-burst
        do_reset();
        for (int j = 0; j < 4; j++) pq[2].push_back(8'hE0 + 8'(j));
        pq[0].push_back(8'hF0); pq[0].push_back(8'hF1);
        en = 4'b0100;
        cycle();
        cycle();
        chk("t6_beat1", 64'(s_wen), 64'd1);
        RST = 1'b1;
        cycle();
        chk("t6_rst_wen", 64'(s_wen), 64'd0);
        chk("t6_rst_ready", 64'(s_ready), 64'd0);
        RST = 1'b0;
        en = 4'b0101;
        cycle();
        chk("t6_post_busy", 64'(s_busy), 64'd0);
        chk("t6_post_wen", 64'(s_wen), 64'd0);
        chk("t6_post_gid", 64'(s_gid), 64'd0);
        cycle();
        chk("t6_next_busy", 64'(s_busy), 64'd1);
        chk("t6_next_gid", 64'(s_gid), 64'd0);
        rd_en = 1'b1;
        for (int k = 0; k < 12; k++) cycle();

`ifdef FIFO_ARB_STATS_EN
        // Statistics counter and clear
        do_reset();
        for (int j = 0; j < 5; j++) pq[1].push_back(8'h50 + 8'(j));
        en = 4'b0010;
        rd_en = 1'b1;
        for (int k = 0; k < 12; k++) cycle();
        chk("stat_cnt1", 64'(s_stat[63:32]), 64'd5);
        chk("stat_cnt0", 64'(s_stat[31:0]), 64'd0);
        for (int j = 0; j < 3; j++) pq[1].push_back(8'h60 + 8'(j));
        cycle();
        STAT_CLR = 1'b1;
        cycle();
        chk("stat_clr_xfer", 64'(s_wen), 64'd1);
        STAT_CLR = 1'b0;
        cycle();
        chk("stat_cleared", 64'(s_stat[63:32]), 64'd0);
        for (int k = 0; k < 6; k++) cycle();
`endif

        // Randomized traffic with slow then fast FIFO drain
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if ($urandom_range(0, 5) == 0 && pq[i].size() < 12)
                    pq[i].push_back(8'($urandom));
                if (!valid[i] || acc[i])
                    en[i] = ($urandom_range(0, 4) != 0);
            end
            rd_en = (k < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle();
        end
        en = '1;
        rd_en = 1'b1;
        total = 0;
        for (int i = 0; i < N_REQ; i++) total += pq[i].size();
        for (int k = 0; k < 600 && (total > 0 || s_busy); k++) begin
            cycle();
            total = 0;
            for (int i = 0; i < N_REQ; i++) total += pq[i].size();
        end
        chk("rand_drained", 64'(total), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
